// File: rtl/seq_alu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : seq_alu_pkg
//  Description : Opcodes, error codes and FSM states shared by seq_alu.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_ADD = 3'b000;
    localparam logic [OPW-1:0] OP_SUB = 3'b001;
    localparam logic [OPW-1:0] OP_MUL = 3'b010;
    localparam logic [OPW-1:0] OP_DIV = 3'b011;
    localparam logic [OPW-1:0] OP_MOD = 3'b100;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_DIV0    = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : seq_alu_if
//  Description : Command/response handshake bundle between parser and ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic                          in_valid;
    logic                          in_ready;
    logic [seq_alu_pkg::OPW-1:0]   opcode;
    logic [WIDTH-1:0]              op1;
    logic [WIDTH-1:0]              op2;
    logic                          out_valid;
    logic                          out_ready;
    logic [WIDTH-1:0]              result;
    logic                          ovf;
    logic [1:0]                    err;

    modport master (
        output in_valid, opcode, op1, op2, out_ready,
        input  in_ready, out_valid, result, ovf, err
    );

    modport slave (
        input  in_valid, opcode, op1, op2, out_ready,
        output in_ready, out_valid, result, ovf, err
    );
endinterface
`default_nettype wire

// File: rtl/seq_alu_div_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : div_iter
//  Description : Unsigned restoring divider, one quotient bit per cycle, MSB
//                first, fixed WIDTH-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int c_cnt_w = $clog2(WIDTH + 1);

    logic [WIDTH:0]       r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_dvsr;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_busy;

    logic [WIDTH+1:0]     w_shift;
    logic [WIDTH+1:0]     w_trial;
    logic                 w_fits;
    logic [WIDTH:0]       w_rem_next;
    logic [WIDTH-1:0]     w_quo_next;

    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_shift - {2'b00, r_dvsr};
    assign w_fits     = ~w_trial[WIDTH+1];
    assign w_rem_next = w_fits ? w_trial[WIDTH:0] : w_shift[WIDTH:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_fits};

    // The last step is presented combinationally so the caller can register
    // the final answer on the same edge that ends the WIDTH-th iteration.
    assign busy      = r_busy;
    assign done      = r_busy && (r_cnt == c_cnt_w'(1));
    assign quotient  = w_quo_next;
    assign remainder = w_rem_next[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvsr <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_rem  <= '0;
            r_quo  <= dividend;
            r_dvsr <= divisor;
            r_cnt  <= c_cnt_w'(WIDTH);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt - c_cnt_w'(1);
            if (r_cnt == c_cnt_w'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Multi-cycle signed ALU with valid/ready handshakes; single-
//                cycle add/sub/mul, iterative div/mod.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    seq_alu_if.slave  bus
);
    state_t               r_state;
    state_t               w_state_next;

    logic [WIDTH-1:0]     r_result;
    logic                 r_ovf;
    logic [1:0]           r_err;
    logic                 r_is_mod;
    logic                 r_qneg;
    logic                 r_rneg;

    logic                 w_accept;
    logic                 w_start;
    logic                 w_is_divmod;
    logic                 w_div0;
    logic                 w_load_fast;
    logic                 w_load_div;

    logic [WIDTH-1:0]     w_sum;
    logic [WIDTH-1:0]     w_diff;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_fast_result;
    logic                 w_fast_ovf;
    logic [1:0]           w_fast_err;

    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_div_busy;
    logic                 w_div_done;
    logic [WIDTH-1:0]     w_q_mag;
    logic [WIDTH-1:0]     w_r_mag;
    logic [WIDTH-1:0]     w_q_signed;
    logic [WIDTH-1:0]     w_r_signed;
    logic                 w_div_ovf;

    assign bus.in_ready  = (r_state == IDLE) && !rst;
    assign bus.out_valid = (r_state == DONE);
    assign bus.result    = r_result;
    assign bus.ovf       = r_ovf;
    assign bus.err       = r_err;

    assign w_accept    = bus.in_valid && bus.in_ready;
    assign w_is_divmod = (bus.opcode == OP_DIV) || (bus.opcode == OP_MOD);
    assign w_div0      = (bus.op2 == '0);
    assign w_start     = w_accept && w_is_divmod && !w_div0;

    assign w_sum  = bus.op1 + bus.op2;
    assign w_diff = bus.op1 - bus.op2;
    assign w_prod = {{WIDTH{bus.op1[WIDTH-1]}}, bus.op1} *
                    {{WIDTH{bus.op2[WIDTH-1]}}, bus.op2};

    always_comb begin
        w_fast_result = '0;
        w_fast_ovf    = 1'b0;
        w_fast_err    = ERR_NONE;
        case (bus.opcode)
            OP_ADD: begin
                w_fast_result = w_sum;
                w_fast_ovf    = (bus.op1[WIDTH-1] == bus.op2[WIDTH-1]) &&
                                (w_sum[WIDTH-1] != bus.op1[WIDTH-1]);
            end
            OP_SUB: begin
                w_fast_result = w_diff;
                w_fast_ovf    = (bus.op1[WIDTH-1] != bus.op2[WIDTH-1]) &&
                                (w_diff[WIDTH-1] != bus.op1[WIDTH-1]);
            end
            OP_MUL: begin
                w_fast_result = w_prod[WIDTH-1:0];
                // Product fits only if the upper half plus the result sign bit agree.
                w_fast_ovf    = !((&w_prod[2*WIDTH-1:WIDTH-1]) ||
                                  !(|w_prod[2*WIDTH-1:WIDTH-1]));
            end
            OP_DIV, OP_MOD: w_fast_err = ERR_DIV0;
            default:        w_fast_err = ERR_ILLEGAL;
        endcase
    end

    assign w_a_mag = bus.op1[WIDTH-1] ? -bus.op1 : bus.op1;
    assign w_b_mag = bus.op2[WIDTH-1] ? -bus.op2 : bus.op2;

    div_iter #(
        .WIDTH (WIDTH)
    ) u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (w_start),
        .dividend  (w_a_mag),
        .divisor   (w_b_mag),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quotient  (w_q_mag),
        .remainder (w_r_mag)
    );

    assign w_q_signed = r_qneg ? -w_q_mag : w_q_mag;
    assign w_r_signed = r_rneg ? -w_r_mag : w_r_mag;
    // A non-negative quotient of magnitude 2^(WIDTH-1) only arises from MIN / -1.
    assign w_div_ovf  = !r_is_mod && !r_qneg && w_q_mag[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_fast  = 1'b0;
        w_load_div   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = w_start ? DIV : DONE;
                    w_load_fast  = !w_start;
                end
            end
            DIV: begin
                if (w_div_busy && w_div_done) begin
                    w_state_next = DONE;
                    w_load_div   = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_err    <= ERR_NONE;
            r_is_mod <= 1'b0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
        end else begin
            if (w_start) begin
                r_is_mod <= (bus.opcode == OP_MOD);
                r_qneg   <= bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1];
                r_rneg   <= bus.op1[WIDTH-1];
            end
            if (w_load_fast) begin
                r_result <= w_fast_result;
                r_ovf    <= w_fast_ovf;
                r_err    <= w_fast_err;
            end else if (w_load_div) begin
                r_result <= r_is_mod ? w_r_signed : w_q_signed;
                r_ovf    <= w_div_ovf;
                r_err    <= ERR_NONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu
//  Description : Directed self-checking bench for seq_alu with a behavioural
//                reference model and a per-cycle handshake monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 8;
    localparam longint c_maxv = (64'sd1 <<< (W - 1)) - 64'sd1;
    localparam longint c_minv = -(64'sd1 <<< (W - 1));

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer arithmetic, then wrap and range-check.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic o, output logic [1:0] e, output int lat);
        longint sa;
        longint sb;
        longint t;
        sa  = $signed(a);
        sb  = $signed(b);
        t   = 0;
        e   = 2'b00;
        lat = 1;
        case (op)
            3'd0: t = sa + sb;
            3'd1: t = sa - sb;
            3'd2: t = sa * sb;
            3'd3, 3'd4: begin
                if (sb == 0) begin
                    e = 2'b01;
                end else begin
                    t   = (op == 3'd3) ? sa / sb : sa % sb;
                    lat = W + 1;
                end
            end
            default: e = 2'b10;
        endcase
        r = t[W-1:0];
        o = (e == 2'b00) && ((t < c_minv) || (t > c_maxv));
    endfunction

    logic            m_pending;
    int              m_wait;
    logic            m_valid;
    logic [W-1:0]    m_r;
    logic            m_o;
    logic [1:0]      m_e;

    always @(negedge clk) begin
        if (rst) begin
            m_pending = 1'b0;
            chk("mon_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("mon_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
            chk("mon_rst_result", {24'd0, bus.result}, 32'd0);
        end else begin
            if (m_pending && m_wait > 0) m_wait--;
            m_valid = m_pending && (m_wait == 0);
            chk("mon_in_ready", {31'd0, bus.in_ready}, {31'd0, !m_pending});
            chk("mon_out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
            if (m_valid) begin
                chk("mon_result", {24'd0, bus.result}, {24'd0, m_r});
                chk("mon_ovf", {31'd0, bus.ovf}, {31'd0, m_o});
                chk("mon_err", {30'd0, bus.err}, {30'd0, m_e});
            end
            if (m_valid && bus.out_ready) begin
                m_pending = 1'b0;
            end else if (!m_pending && bus.in_valid) begin
                model(bus.opcode, bus.op1, bus.op2, m_r, m_o, m_e, m_wait);
                m_pending = 1'b1;
            end
        end
    end

    // Enters and leaves one time unit after a rising edge.
    task automatic run_cmd(input string name, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] er, input logic eo,
                           input logic [1:0] ee, input int elat);
        int t;
        int lat;
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.op1      = a;
        bus.op2      = b;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_accept"}, {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.opcode   = 3'b111;
        bus.op1      = ~a;
        bus.op2      = ~b;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 50);
        chk({name, "_latency"}, lat, elat);
        chk({name, "_result"}, {24'd0, bus.result}, {24'd0, er});
        chk({name, "_ovf"}, {31'd0, bus.ovf}, {31'd0, eo});
        chk({name, "_err"}, {30'd0, bus.err}, {30'd0, ee});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        m_pending    = 1'b0;
        m_wait       = 0;
        clk          = 1'b0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.opcode   = 3'b000;
        bus.op1      = '0;
        bus.op2      = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("reset_ovf", {31'd0, bus.ovf}, 32'd0);
        chk("reset_err", {30'd0, bus.err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_cmd("add_100_50",   OP_ADD, 8'd100,  8'd50,  8'h96, 1'b1, 2'b00, 1);
        run_cmd("sub_m128_1",   OP_SUB, 8'h80,   8'd1,   8'h7F, 1'b1, 2'b00, 1);
        run_cmd("mul_m12_11",   OP_MUL, 8'hF4,   8'd11,  8'h7C, 1'b1, 2'b00, 1);
        run_cmd("mul_12_m10",   OP_MUL, 8'd12,   8'hF6,  8'h88, 1'b0, 2'b00, 1);
        run_cmd("div_m7_2",     OP_DIV, 8'hF9,   8'd2,   8'hFD, 1'b0, 2'b00, 9);
        run_cmd("mod_m7_2",     OP_MOD, 8'hF9,   8'd2,   8'hFF, 1'b0, 2'b00, 9);
        run_cmd("div_7_m2",     OP_DIV, 8'd7,    8'hFE,  8'hFD, 1'b0, 2'b00, 9);
        run_cmd("div_m128_m1",  OP_DIV, 8'h80,   8'hFF,  8'h80, 1'b1, 2'b00, 9);
        run_cmd("mod_m128_m1",  OP_MOD, 8'h80,   8'hFF,  8'h00, 1'b0, 2'b00, 9);
        run_cmd("div_100_7",    OP_DIV, 8'd100,  8'd7,   8'h0E, 1'b0, 2'b00, 9);
        run_cmd("mod_100_m7",   OP_MOD, 8'd100,  8'hF9,  8'h02, 1'b0, 2'b00, 9);
        run_cmd("div_5_0",      OP_DIV, 8'd5,    8'd0,   8'h00, 1'b0, 2'b01, 1);
        run_cmd("mod_5_0",      OP_MOD, 8'd5,    8'd0,   8'h00, 1'b0, 2'b01, 1);
        run_cmd("illegal_110",  3'b110, 8'd5,    8'd3,   8'h00, 1'b0, 2'b10, 1);

        // Backpressure with a second command waiting.
        bus.out_ready = 1'b0;
        run_cmd("bp_add_3_4",   OP_ADD, 8'd3,    8'd4,   8'h07, 1'b0, 2'b00, 1);
        bus.in_valid = 1'b1;
        bus.opcode   = OP_SUB;
        bus.op1      = 8'd3;
        bus.op2      = 8'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_hold_result", {24'd0, bus.result}, 32'h07);
            chk("bp_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {31'd0, bus.out_valid}, 32'd1);
        @(negedge clk);
        chk("bp_idle_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_queued_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_queued_result", {24'd0, bus.result}, 32'hFE);
        @(posedge clk);
        #1;

        // Reset in the middle of a division.
        bus.in_valid = 1'b1;
        bus.opcode   = OP_DIV;
        bus.op1      = 8'd100;
        bus.op2      = 8'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_mid_result", {24'd0, bus.result}, 32'd0);
        chk("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        run_cmd("post_rst_add", OP_ADD, 8'd1,    8'd1,   8'h02, 1'b0, 2'b00, 1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
